// File: rtl/dff_arb_pkg.sv
// Shared types and constants for the DFF bank arbiter.
// Holds the FSM state encoding, the settle counter width and a clog2 helper.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

  localparam int SETTLE_CNT_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above pointer,
// wrapping modulo N.
module rr_picker
  import dff_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [PW-1:0] winner,
  output logic          valid
);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  always_comb begin
    // Rotate so bit 0 is the requester at the pointer, then find the lowest set bit.
    rot = N'({req, req} >> pointer);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    sum = {1'b0, pointer} + {1'b0, off};
    if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
    winner = sum[PW-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Optional DFF_ARB_LOCK_EN adds a lock port that lets the owner re-grant after settle.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N             = 4,
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*WIDTH-1:0]    wdata,
`ifdef DFF_ARB_LOCK_EN
  input  logic [N-1:0]          lock,
`endif
  output logic [N-1:0]          gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  upd,
  output logic [clog2(N)-1:0]   owner,
  output logic                  busy
);

  localparam int OW = clog2(N);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
    SETTLE_CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);

  arb_state_t              state, state_nxt;
  logic [OW-1:0]           ptr, ptr_nxt, owner_nxt, win;
  logic                    win_vld;
  logic [SETTLE_CNT_W-1:0] cnt, cnt_nxt;
  logic [N-1:0]            gnt_nxt;
  logic                    wr_en;
  logic [WIDTH-1:0]        lane [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane[i] = wdata[i*WIDTH +: WIDTH];
  end

  rr_picker #(.N(N)) u_picker (
    .req     (req),
    .pointer (ptr),
    .winner  (win),
    .valid   (win_vld)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    wr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_nxt   = N'(1) << win;
          owner_nxt = win;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // A requester that dropped req during its grant forfeits the write.
        wr_en     = req[owner];
        ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        cnt_nxt   = '0;
        state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = IDLE;
`ifdef DFF_ARB_LOCK_EN
          if (lock[owner] && req[owner]) begin
            state_nxt = GRANT;
            gnt_nxt   = N'(1) << owner;
          end
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      gnt   <= '0;
      upd   <= 1'b0;
      busy  <= 1'b0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      upd   <= wr_en;
      busy  <= (state_nxt != IDLE);
      if (wr_en) q <= lane[owner];
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter (N=4, WIDTH=8, SETTLE_CYCLES=2): per-cycle model
// comparison plus directed literal checks.
module tb_dff_bank_arbiter;

  localparam int N      = 4;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req   = '0;
  logic [N*WIDTH-1:0] wdata = '0;
`ifdef DFF_ARB_LOCK_EN
  logic [N-1:0]     lock  = '0;
`endif
  logic [N-1:0]     gnt;
  logic [WIDTH-1:0] q;
  logic             upd;
  logic [1:0]       owner;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.N(N), .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
`ifdef DFF_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .q     (q),
    .upd   (upd),
    .owner (owner),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [WIDTH-1:0] lane_of(input int i);
    return wdata[i*WIDTH +: WIDTH];
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: m_free counts the busy cycles left after a grant; zero means arbitration is open.
  logic [N-1:0]     m_gnt = '0;
  logic [N-1:0]     m_g;
  logic [WIDTH-1:0] m_q   = '0;
  logic             m_upd = 1'b0;
  int               m_owner = 0, m_ptr = 0, m_free = 0, m_w;

  always @(posedge clk) begin
    if (!reset) begin
      m_gnt = '0; m_q = '0; m_upd = 1'b0;
      m_owner = 0; m_ptr = 0; m_free = 0;
    end else begin
      m_g   = '0;
      m_upd = 1'b0;
      if (m_gnt != '0) begin
        if (req[m_owner]) begin
          m_q   = lane_of(m_owner);
          m_upd = 1'b1;
        end
        m_ptr = (m_owner + 1) % N;
      end
      if (m_free == 0) begin
        if (req != '0) begin
          m_w = -1;
          for (int k = 0; k < N; k++)
            if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
          m_g     = N'(1) << m_w;
          m_owner = m_w;
          m_free  = 1 + SETTLE;
        end
      end else begin
        m_free--;
`ifdef DFF_ARB_LOCK_EN
        if (m_free == 0 && SETTLE > 0 && lock[m_owner] && req[m_owner]) begin
          m_g    = N'(1) << m_owner;
          m_free = 1 + SETTLE;
        end
`endif
      end
      m_gnt = m_g;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",   gnt,   m_gnt);
      check("q",     q,     m_q);
      check("upd",   upd,   m_upd);
      check("owner", owner, m_owner[1:0]);
      check("busy",  busy,  (m_free != 0));
    end
  end

  int         gi, pending;
  int         gcyc [5];
  int         gown [5];
  logic [7:0] gq   [5];
  int         exp_own [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_q   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`ifdef DFF_ARB_LOCK_EN
  int         lk_own [4] = '{3, 3, 3, 0};
  int         lk_cyc [4] = '{1, 4, 7, 11};
`endif

  initial begin
    // Reset held with all requests asserted.
    reset = 1'b0;
    req   = '1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt",  gnt,  4'b0000);
      check("rst_q",    q,    8'h00);
      check("rst_upd",  upd,  1'b0);
      check("rst_busy", busy, 1'b0);
    end

    // Single request on lane 2.
    reset = 1'b1;
    req   = 4'b0100;
    set_lane(2, 8'hA5);
    @(negedge clk);
    check("t2_gnt",   gnt,   4'b0100);
    check("t2_owner", owner, 2'd2);
    check("t2_busy1", busy,  1'b1);
    check("t2_upd0",  upd,   1'b0);
    @(negedge clk);
    check("t2_q",     q,     8'hA5);
    check("t2_upd",   upd,   1'b1);
    check("t2_busy2", busy,  1'b1);
    req = '0;
    @(negedge clk);
    check("t2_busy3", busy,  1'b1);
    @(negedge clk);
    check("t2_busy4", busy,  1'b0);

    // All four requesting from pointer 0.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'h33); set_lane(3, 8'h44);
    req = '1;
    gi = 0; pending = -1;
    for (int k = 0; k < 5; k++) begin gcyc[k] = -1; gown[k] = -1; gq[k] = '0; end
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (pending >= 0) begin gq[pending] = q; pending = -1; end
      if (gnt != '0 && gi < 5) begin
        gcyc[gi] = c; gown[gi] = onehot_idx(gnt); pending = gi; gi++;
      end
    end
    req = '0;
    check("t3_count", gi, 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_own%0d", k), gown[k], exp_own[k]);
      check($sformatf("t3_q%0d", k), gq[k], exp_q[k]);
      if (k > 0) check($sformatf("t3_gap%0d", k), gcyc[k] - gcyc[k-1], 4);
    end
    repeat (4) @(negedge clk);

    // Requester 1 drops req during its grant cycle.
    set_lane(1, 8'h5B);
    set_lane(2, 8'hC3);
    req = 4'b0110;
    @(negedge clk);
    check("t4_gnt1", gnt, 4'b0010);
    req = 4'b0100;
    @(negedge clk);
    check("t4_upd0", upd, 1'b0);
    check("t4_qhold", q, 8'h11);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("t4_gnt2", gnt, 4'b0100);
    @(negedge clk);
    check("t4_q", q, 8'hC3);
    check("t4_upd", upd, 1'b1);
    req = '0;
    repeat (3) @(negedge clk);

    // Reset during a grant abandons the write and rewinds the pointer.
    set_lane(2, 8'h7E);
    req = 4'b0100;
    @(negedge clk);
    check("t5_gnt", gnt, 4'b0100);
    reset = 1'b0;
    @(negedge clk);
    check("t5_q0",    q,     8'h00);
    check("t5_gnt0",  gnt,   4'b0000);
    check("t5_busy0", busy,  1'b0);
    check("t5_upd0",  upd,   1'b0);
    check("t5_own0",  owner, 2'd0);
    reset = 1'b1;
    set_lane(3, 8'h99);
    req = 4'b1100;
    @(negedge clk);
    check("t5_gnt_ptr0", gnt, 4'b0100);
    @(negedge clk);
    check("t5_q", q, 8'h7E);
    req = '0;
    repeat (3) @(negedge clk);

`ifdef DFF_ARB_LOCK_EN
    // Owner 3 holds the register via lock, then releases it to requester 0.
    req  = 4'b1001;
    lock = 4'b1000;
    gi = 0;
    for (int k = 0; k < 4; k++) begin gcyc[k] = -1; gown[k] = -1; end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (gnt != '0 && gi < 4) begin gcyc[gi] = c; gown[gi] = onehot_idx(gnt); gi++; end
      if (c == 7) lock = '0;
    end
    req = '0;
    check("t6_count", gi, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_own%0d", k), gown[k], lk_own[k]);
      check($sformatf("t6_cyc%0d", k), gcyc[k], lk_cyc[k]);
    end
    repeat (4) @(negedge clk);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer sharing one WIDTH-bit D-flip-flop storage register among N requesters.
- Each requester presents req plus write data. The arbiter grants one requester at a time and loads its data into the shared register.
- It then enforces a programmable settle window before the next grant.
- Sits in front of the gate-level flip-flop storage and is its only writer.

Parameters:
- N, 4, number of requesters (2..16)
- WIDTH, 8, width of the shared register and of each write-data lane
- SETTLE_CYCLES, 2, idle cycles after each write before re-arbitration (0..15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous active-low reset
- req  input  N  request per requester; level, held until grant seen
- wdata  input  N*WIDTH  write data; lane i = bits [i*WIDTH +: WIDTH]
- gnt  output  N  one-hot grant; high for exactly one cycle per write
- q  output  WIDTH  shared register contents
- upd  output  1  one-cycle pulse in the cycle after q was written
- owner  output  clog2(N)  index of last granted requester
- busy  output  1  high in GRANT and SETTLE states
- lock  input  N  present only when DFF_ARB_LOCK_EN is defined

Behaviour:
- Reset: sampled on rising clk while reset==0. Forces:
  - state=IDLE
  - q=0, gnt=0, upd=0, owner=0, busy=0
  - rr pointer=0, settle counter=0
- Reset mid-GRANT abandons the pending write; q stays 0.
- FSM states: IDLE, GRANT, SETTLE.
- IDLE, any req high:
  - Winner = first set req bit at or above pointer, wrapping modulo N.
  - Next cycle: gnt=onehot(winner), owner=winner, state=GRANT.
- IDLE, no req: remain in IDLE with gnt=0.
- GRANT (exactly 1 cycle):
  - If req[owner] is still high: q <= wdata lane owner at cycle end, and upd=1 in the following cycle.
  - If req[owner] has dropped: no write, upd stays 0.
  - pointer <= (owner+1) mod N in both cases.
  - Next state: SETTLE if SETTLE_CYCLES>0, else IDLE.
- SETTLE:
  - gnt=0; counter counts SETTLE_CYCLES cycles, then state=IDLE.
  - Requests arriving during SETTLE are ignored until IDLE.
- Latency: req high in IDLE at cycle t -> gnt at t+1 -> q updated and upd at t+2.
- Minimum grant spacing is 2+SETTLE_CYCLES cycles (IDLE+GRANT+SETTLE).
- Simultaneous requests: round-robin order only; no starvation. Each requester waits at most N grants.
- Pointer wrap: owner N-1 -> pointer 0.
- wdata lanes of non-winners are don't-care.
- Outputs are fully registered; no combinational path from req to gnt.

Optional Feature:
- Macro DFF_ARB_LOCK_EN.
- Defined:
  - lock port exists.
  - At SETTLE exit, if lock[owner] && req[owner], go directly to GRANT for the same owner; pointer is not advanced and the IDLE cycle is skipped.
  - lock is ignored for non-owners.
- Undefined:
  - No lock port; pure round-robin as above.

Decomposition:
- Package dff_arb_pkg holds:
  - state enum (IDLE=2'd0, GRANT=2'd1, SETTLE=2'd2)
  - localparam-style helper for clog2
  - settle counter width constant (4)
- One sub-module, rr_picker: combinational; inputs req[N] and pointer; outputs winner index and valid. Instantiated once.

Test Plan (N=4, WIDTH=8, SETTLE_CYCLES=2):
1. Reset hold 3 cycles with req=4'b1111 -> gnt=0, q=0x00, upd=0, busy=0 throughout.
2. Single req[2]=1, lane2=0xA5 at cycle t -> gnt=4'b0100 at t+1; q=0xA5, upd=1 at t+2; busy high t+1..t+3; owner=2.
3. req=4'b1111, lanes 0x11/0x22/0x33/0x44, held -> grants in order 0,1,2,3,0, spaced 4 cycles apart; q sequence 0x11,0x22,0x33,0x44,0x11.
4. req[1] drops in the GRANT cycle -> q unchanged, upd=0; next grant goes to requester 2 if it is requesting.
5. Reset asserted during GRANT for lane 0x7E -> q=0x00 after the edge and state=IDLE; the following arbitration starts from pointer 0.
6. DFF_ARB_LOCK_EN defined, lock[3]=1 with req=4'b1001 -> requester 3 is granted repeatedly every 3 cycles; on lock[3]=0, the next grant goes to requester 0.
